stb_drain_ctrl: RTL

Store-buffer drain controller and D-cache port arbiter. Sits between the LSU, the store buffer FIFO and the single D-cache request port. It pops committed stores from the store buffer head and shares the port with LSU loads using load-priority arbitration, bounded by a starvation limit, a full-buffer override and a flush request. One request/acknowledge transaction is outstanding at a time.

---
 rtl/stb_drain_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/stb_drain_ctrl.sv
// stb_drain_ctrl
//   Store-buffer drain controller and D-cache port arbiter. It pops committed
//   stores from the store-buffer head and shares the single D-cache request
//   port with LSU loads. Loads have priority, bounded by a starvation limit,
//   a full-buffer override and a flush request. Only one request/ack
//   transaction is outstanding at a time.
//
// Optional feature macro: STB_CTRL_RAW_CHECK_EN
//   When defined, a load whose address matches the store-buffer head address
//   forces the head store to drain first (read-after-write ordering).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   stb_empty, stb_full          store-buffer status
//   stb2ctrl_addr/wdata/sel_byte head entry (combinational from the FIFO)
//   stb_rd_en                    pop strobe, high in the store ack cycle
//   lsu2ctrl_ld_req/ld_addr      load request, held until ctrl2lsu_ld_ack
//   ctrl2lsu_ld_ack/ld_rdata     load completion pulse and data
//   lsu2ctrl_flush               flush request pulse
//   ctrl2lsu_flush_done          flush completion pulse
//   ctrl2dcache_*                D-cache request fields
//   dcache2ctrl_ack/rdata        D-cache acknowledge and load data
//
// state  | meaning
// IDLE   | no transaction; arbitration evaluated here
// ST_REQ | store request presented, waiting for D-cache ack
// LD_REQ | load request presented, waiting for D-cache ack
module stb_drain_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int SEL_W         = 4,
  parameter int LD_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_empty,
  input  logic              stb_full,
  input  logic [ADDR_W-1:0] stb2ctrl_addr,
  input  logic [DATA_W-1:0] stb2ctrl_wdata,
  input  logic [SEL_W-1:0]  stb2ctrl_sel_byte,
  output logic              stb_rd_en,
  input  logic              lsu2ctrl_ld_req,
  input  logic [ADDR_W-1:0] lsu2ctrl_ld_addr,
  output logic              ctrl2lsu_ld_ack,
  output logic [DATA_W-1:0] ctrl2lsu_ld_rdata,
  input  logic              lsu2ctrl_flush,
  output logic              ctrl2lsu_flush_done,
  output logic              ctrl2dcache_req,
  output logic              ctrl2dcache_wr,
  output logic [ADDR_W-1:0] ctrl2dcache_addr,
  output logic [DATA_W-1:0] ctrl2dcache_wdata,
  output logic [SEL_W-1:0]  ctrl2dcache_sel_byte,
  input  logic              dcache2ctrl_ack,
  input  logic [DATA_W-1:0] dcache2ctrl_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_REQ = 2'd1,
    LD_REQ = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(LD_STARVE_MAX);

  state_t              state_q;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                flush_pending_q, flush_pending_d;
  logic                req_q, wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SEL_W-1:0]    sel_q;
  logic                ld_ack_q;
  logic [DATA_W-1:0]   ld_rdata_q;

  logic raw_hit, ld_ok, grant_st, grant_ld, flush_done;

`ifdef STB_CTRL_RAW_CHECK_EN
  assign raw_hit = lsu2ctrl_ld_req && !stb_empty && (lsu2ctrl_ld_addr == stb2ctrl_addr);
`else
  assign raw_hit = 1'b0;
`endif

  assign ld_ok = lsu2ctrl_ld_req && !flush_pending_q;

  // Priority-ordered grant; only meaningful while IDLE.
  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (state_q == IDLE) begin
      if (flush_pending_q && !stb_empty)                           grant_st = 1'b1;
      else if (stb_full)                                           grant_st = 1'b1;
      else if (raw_hit)                                            grant_st = 1'b1;
      else if (ld_ok && (stb_empty || starve_cnt_q < STARVE_MAX))  grant_ld = 1'b1;
      else if (!stb_empty)                                         grant_st = 1'b1;
      else if (ld_ok)                                              grant_ld = 1'b1;
    end
  end

  // Gated by rst so a reset landing on an ack cycle neither pops nor
  // reports a completed flush.
  assign flush_done = !rst && flush_pending_q && (state_q == IDLE) && stb_empty;
  assign stb_rd_en  = !rst && (state_q == ST_REQ) && dcache2ctrl_ack;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (stb_empty || grant_st)
      starve_cnt_d = 4'd0;
    else if (grant_ld && starve_cnt_q != 4'hF)
      starve_cnt_d = starve_cnt_q + 4'd1;

    // A pulse arriving in the completion cycle is absorbed by that flush.
    flush_pending_d = flush_done ? 1'b0 : (flush_pending_q | lsu2ctrl_flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      starve_cnt_q    <= 4'd0;
      flush_pending_q <= 1'b0;
      req_q           <= 1'b0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      sel_q           <= '0;
      ld_ack_q        <= 1'b0;
      ld_rdata_q      <= '0;
    end else begin
      starve_cnt_q    <= starve_cnt_d;
      flush_pending_q <= flush_pending_d;
      ld_ack_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_st) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= stb2ctrl_addr;
            wdata_q <= stb2ctrl_wdata;
            sel_q   <= stb2ctrl_sel_byte;
          end else if (grant_ld) begin
            state_q <= LD_REQ;
            req_q   <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= lsu2ctrl_ld_addr;
            wdata_q <= '0;
            sel_q   <= '0;
          end
        end
        ST_REQ, LD_REQ: begin
          if (dcache2ctrl_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            if (state_q == LD_REQ) begin
              ld_ack_q   <= 1'b1;
              ld_rdata_q <= dcache2ctrl_rdata;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl2dcache_req      = req_q;
  assign ctrl2dcache_wr       = wr_q;
  assign ctrl2dcache_addr     = addr_q;
  assign ctrl2dcache_wdata    = wdata_q;
  assign ctrl2dcache_sel_byte = sel_q;
  assign ctrl2lsu_ld_ack      = ld_ack_q;
  assign ctrl2lsu_ld_rdata    = ld_rdata_q;
  assign ctrl2lsu_flush_done  = flush_done;

endmodule
